// File: rtl/pcie_msg_queue_ctrl.sv
// Per-queue ring-pointer tracking and interrupt coalescing for the PCIe AXI message handler.
// Holds write/read pointers, drop accounting and a sticky W1C interrupt per queue.
module pcie_msg_queue_ctrl #(
  parameter int NUM_Q = 15,
  parameter int PTR_W = 6,
  parameter int TMO_W = 16,
  parameter int QID_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push_valid,
  input  logic [QID_W-1:0]             i_push_qid,
  output logic                         o_push_ack,
  output logic                         o_push_drop,
  output logic [PTR_W-1:0]             o_push_slot,
  input  logic                         i_rptr_we,
  input  logic [QID_W-1:0]             i_rptr_qid,
  input  logic [PTR_W:0]               i_rptr_val,
  output logic                         o_rptr_err,
  input  logic [NUM_Q-1:0]             i_intr_clear,
  input  logic [NUM_Q-1:0]             i_intr_mask,
  input  logic [PTR_W:0]               i_coal_thresh,
  input  logic [TMO_W-1:0]             i_coal_timeout,
  output logic [NUM_Q*(PTR_W+1)-1:0]   o_wptr,
  output logic [NUM_Q-1:0]             o_full,
  output logic [NUM_Q-1:0]             o_empty,
  output logic [NUM_Q-1:0]             o_intr_status,
  output logic                         o_intr,
  output logic [7:0]                   o_drop_cnt
);

  localparam int PW    = PTR_W + 1;
  localparam int DEPTH = 1 << PTR_W;
  localparam int CW    = PTR_W + 2;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} coal_state_t;

  logic [PW-1:0]    wptr_r [NUM_Q];
  logic [PW-1:0]    rptr_r [NUM_Q];
  logic [CW-1:0]    pend_r [NUM_Q];
  logic [TMO_W-1:0] timer_r [NUM_Q];
  coal_state_t      state_r [NUM_Q];
  logic [NUM_Q-1:0] status_r;

  logic [PW-1:0]    wptr_s [NUM_Q];
  logic [PW-1:0]    rptr_s [NUM_Q];
  logic [CW-1:0]    pend_s [NUM_Q];
  logic [TMO_W-1:0] timer_s [NUM_Q];
  coal_state_t      state_s [NUM_Q];
  logic [PW-1:0]    level_s [NUM_Q];
  logic [PW-1:0]    rdiff_s [NUM_Q];
  logic [CW-1:0]    pend_sum_s [NUM_Q];
  logic [TMO_W-1:0] timer_sum_s [NUM_Q];
  logic [NUM_Q-1:0] push_ok_s, rptr_ok_s, fire_s, status_s;
  logic [PW-1:0]    thr_eff_s;
  logic [PTR_W-1:0] slot_s;
  logic             push_acc_s, rptr_acc_s;

  // Occupancy from registered pointers only; the extra pointer MSB separates full from empty.
  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      level_s[q]             = wptr_r[q] - rptr_r[q];
      o_full[q]              = (level_s[q] == PW'(DEPTH));
      o_empty[q]             = (level_s[q] == {PW{1'b0}});
      o_wptr[q*PW +: PW]     = wptr_r[q];
    end
  end

  // Pointer updates and per-queue coalescing next-state; all checks use pre-edge pointers.
  always_comb begin
    thr_eff_s  = (i_coal_thresh == {PW{1'b0}}) ? {{(PW-1){1'b0}}, 1'b1} : i_coal_thresh;
    slot_s     = {PTR_W{1'b0}};
    push_ok_s  = {NUM_Q{1'b0}};
    rptr_ok_s  = {NUM_Q{1'b0}};
    fire_s     = {NUM_Q{1'b0}};
    for (int q = 0; q < NUM_Q; q++) begin
      rdiff_s[q]   = wptr_r[q] - i_rptr_val;
      push_ok_s[q] = i_push_valid && (i_push_qid == QID_W'(q)) && !o_full[q];
      rptr_ok_s[q] = i_rptr_we && (i_rptr_qid == QID_W'(q)) && (rdiff_s[q] <= PW'(DEPTH));
      slot_s       = slot_s | (push_ok_s[q] ? wptr_r[q][PTR_W-1:0] : {PTR_W{1'b0}});
      wptr_s[q]    = push_ok_s[q] ? (wptr_r[q] + {{(PW-1){1'b0}}, 1'b1}) : wptr_r[q];
      rptr_s[q]    = rptr_ok_s[q] ? i_rptr_val : rptr_r[q];

      pend_sum_s[q] = pend_r[q] + {{(CW-1){1'b0}}, push_ok_s[q]};
      if (push_ok_s[q]) begin
        timer_sum_s[q] = {TMO_W{1'b0}};
      end else if (state_r[q] == ACCUM && timer_r[q] != {TMO_W{1'b1}}) begin
        timer_sum_s[q] = timer_r[q] + {{(TMO_W-1){1'b0}}, 1'b1};
      end else if (state_r[q] == ACCUM) begin
        timer_sum_s[q] = timer_r[q];
      end else begin
        timer_sum_s[q] = {TMO_W{1'b0}};
      end

      fire_s[q] = (pend_sum_s[q] != {CW{1'b0}}) &&
                  ((pend_sum_s[q] >= CW'(thr_eff_s)) ||
                   ((i_coal_timeout != {TMO_W{1'b0}}) && (timer_sum_s[q] >= i_coal_timeout)));

      if (fire_s[q] || pend_sum_s[q] == {CW{1'b0}}) begin
        state_s[q] = IDLE;
        pend_s[q]  = {CW{1'b0}};
        timer_s[q] = {TMO_W{1'b0}};
      end else begin
        state_s[q] = ACCUM;
        pend_s[q]  = pend_sum_s[q];
        timer_s[q] = timer_sum_s[q];
      end
    end
    push_acc_s = |push_ok_s;
    rptr_acc_s = |rptr_ok_s;
    status_s   = (status_r & ~i_intr_clear) | fire_s;
  end

  assign o_intr_status = status_r;

  // State registers and registered pulse/level outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < NUM_Q; q++) begin
        wptr_r[q]  <= {PW{1'b0}};
        rptr_r[q]  <= {PW{1'b0}};
        pend_r[q]  <= {CW{1'b0}};
        timer_r[q] <= {TMO_W{1'b0}};
        state_r[q] <= IDLE;
      end
      status_r    <= {NUM_Q{1'b0}};
      o_intr      <= 1'b0;
      o_push_ack  <= 1'b0;
      o_push_drop <= 1'b0;
      o_push_slot <= {PTR_W{1'b0}};
      o_rptr_err  <= 1'b0;
      o_drop_cnt  <= 8'd0;
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        wptr_r[q]  <= wptr_s[q];
        rptr_r[q]  <= rptr_s[q];
        pend_r[q]  <= pend_s[q];
        timer_r[q] <= timer_s[q];
        state_r[q] <= state_s[q];
      end
      status_r    <= status_s;
      o_intr      <= |(status_r & ~i_intr_mask);
      o_push_ack  <= push_acc_s;
      o_push_drop <= i_push_valid && !push_acc_s;
      o_rptr_err  <= i_rptr_we && !rptr_acc_s;
      if (push_acc_s) begin
        o_push_slot <= slot_s;
      end else begin
        o_push_slot <= o_push_slot;
      end
      if (i_push_valid && !push_acc_s && o_drop_cnt != 8'hFF) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end else begin
        o_drop_cnt <= o_drop_cnt;
      end
    end
  end

endmodule
